// File: rtl/adf_spi_pkg.sv
// Shared definitions for the ADF PLL sequenced SPI writer: FSM encodings and
// counter width helper.
package adf_spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_CLK_LO = 3'd2;
  localparam state_t ST_CLK_HI = 3'd3;
  localparam state_t ST_TAIL   = 3'd4;
  localparam state_t ST_LATCH  = 3'd5;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/adf_word_fifo.sv
// Synchronous word FIFO; push on full and pop on empty are ignored, and a
// simultaneous push/pop is honoured.
module adf_word_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adf_spi_seq_writer.sv
// Queued ADF4351 register writer: words pushed into a FIFO are shifted out
// MSB-first on ADF_CLK/ADF_DATA, each framed by ADF_LE.
module adf_spi_seq_writer
  import adf_spi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter int LE_HI_CYC = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_VALID,
  input  logic [DATA_W-1:0]       WR_DATA,
  output logic                    WR_READY,
  output logic [$clog2(DEPTH):0]  LEVEL,
  output logic                    BUSY,
  output logic                    WORD_DONE,
  output logic                    SEQ_DONE,
  output logic                    OVF,
  output logic                    ADF_CLK,
  output logic                    ADF_DATA,
  output logic                    ADF_LE
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int LE_W  = cnt_w(LE_HI_CYC);
  localparam int BC_W  = cnt_w(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_HI_CYC - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LE_W-1:0]   le_cnt_q, le_cnt_d;
  logic              clk_q, clk_d, data_q, data_d, le_q, le_d;
  logic              busy_q, busy_d, wd_q, wd_d, sd_q, sd_d, ovf_q, ovf_d;

  logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0] fifo_dout_s;

  assign fifo_push_s = WR_VALID & ~fifo_full_s;

  adf_word_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .data_i  (WR_DATA),
    .data_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (LEVEL)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bitcnt_d   = bitcnt_q;
    div_d      = div_q;
    le_cnt_d   = le_cnt_q;
    clk_d      = clk_q;
    data_d     = data_q;
    le_d       = le_q;
    busy_d     = busy_q;
    wd_d       = 1'b0;
    sd_d       = 1'b0;
    fifo_pop_s = 1'b0;
    // A full FIFO rejects even when a pop happens in the same cycle.
    ovf_d      = ovf_q | (WR_VALID & fifo_full_s);
    case (state_q)
      ST_IDLE: begin
        le_d  = 1'b1;
        clk_d = 1'b0;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          sr_d       = fifo_dout_s;
          bitcnt_d   = BIT_LAST;
          busy_d     = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_LOAD: begin
        le_d    = 1'b0;
        data_d  = sr_q[DATA_W-1];
        div_d   = {DIV_W{1'b0}};
        state_d = ST_CLK_LO;
      end
      ST_CLK_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = {DIV_W{1'b0}};
          clk_d   = 1'b1;
          state_d = ST_CLK_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_CLK_HI: begin
        if (div_q == DIV_LAST) begin
          div_d = {DIV_W{1'b0}};
          clk_d = 1'b0;
          if (bitcnt_q == {BC_W{1'b0}}) begin
            state_d = ST_TAIL;
          end else begin
            bitcnt_d = bitcnt_q - BC_W'(1);
            sr_d     = {sr_q[DATA_W-2:0], 1'b0};
            data_d   = sr_q[DATA_W-2];
            state_d  = ST_CLK_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_TAIL: begin
        if (div_q == DIV_LAST) begin
          div_d    = {DIV_W{1'b0}};
          le_d     = 1'b1;
          wd_d     = 1'b1;
          le_cnt_d = {LE_W{1'b0}};
          state_d  = ST_LATCH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LATCH: begin
        if (le_cnt_q == LE_LAST) begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            sr_d       = fifo_dout_s;
            bitcnt_d   = BIT_LAST;
            state_d    = ST_LOAD;
          end else begin
            busy_d  = 1'b0;
            sd_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          le_cnt_d = le_cnt_q + LE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        clk_d   = 1'b0;
        data_d  = 1'b0;
        le_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      sr_q     <= {DATA_W{1'b0}};
      bitcnt_q <= {BC_W{1'b0}};
      div_q    <= {DIV_W{1'b0}};
      le_cnt_q <= {LE_W{1'b0}};
      clk_q    <= 1'b0;
      data_q   <= 1'b0;
      le_q     <= 1'b1;
      busy_q   <= 1'b0;
      wd_q     <= 1'b0;
      sd_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      le_cnt_q <= le_cnt_d;
      clk_q    <= clk_d;
      data_q   <= data_d;
      le_q     <= le_d;
      busy_q   <= busy_d;
      wd_q     <= wd_d;
      sd_q     <= sd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign WR_READY  = ~fifo_full_s;
  assign BUSY      = busy_q;
  assign WORD_DONE = wd_q;
  assign SEQ_DONE  = sd_q;
  assign OVF       = ovf_q;
  assign ADF_CLK   = clk_q;
  assign ADF_DATA  = data_q;
  assign ADF_LE    = le_q;

endmodule

// File: tb/tb_adf_spi_seq_writer.sv
// Directed bench for adf_spi_seq_writer: default build plus a 24-bit,
// CLK_DIV=1, LE_HI_CYC=1 build.
module tb_adf_spi_seq_writer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, WR_VALID;
  logic [31:0] WR_DATA;
  logic        WR_READY, BUSY, WORD_DONE, SEQ_DONE, OVF, ADF_CLK, ADF_DATA, ADF_LE;
  logic [3:0]  LEVEL;

  logic        WR_VALID5;
  logic [23:0] WR_DATA5;
  logic        WR_READY5, BUSY5, WORD_DONE5, SEQ_DONE5, OVF5, ADF_CLK5, ADF_DATA5, ADF_LE5;
  logic [3:0]  LEVEL5;

  adf_spi_seq_writer #(.DATA_W(32), .DEPTH(8), .CLK_DIV(2), .LE_HI_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .LEVEL(LEVEL), .BUSY(BUSY), .WORD_DONE(WORD_DONE), .SEQ_DONE(SEQ_DONE), .OVF(OVF),
    .ADF_CLK(ADF_CLK), .ADF_DATA(ADF_DATA), .ADF_LE(ADF_LE));

  adf_spi_seq_writer #(.DATA_W(24), .DEPTH(8), .CLK_DIV(1), .LE_HI_CYC(1)) dut5 (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID5), .WR_DATA(WR_DATA5), .WR_READY(WR_READY5),
    .LEVEL(LEVEL5), .BUSY(BUSY5), .WORD_DONE(WORD_DONE5), .SEQ_DONE(SEQ_DONE5), .OVF(OVF5),
    .ADF_CLK(ADF_CLK5), .ADF_DATA(ADF_DATA5), .ADF_LE(ADF_LE5));

  typedef struct {
    logic [31:0] wdata;
    logic [31:0] exp_word;
    int          exp_bits;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;

  // Frame monitor for the default build, sampled on the falling edge.
  int          cyc = 0, nbits = 0, last_rise = -1, le_rise = -1;
  int          gap_bad = 0, wd_cnt = 0, sd_cnt = 0, busy_falls = 0;
  logic        prev_clk = 1'b0, prev_le = 1'b1, prev_busy = 1'b0, rst_prev = 1'b1;
  logic [31:0] cap = 32'd0;
  logic [31:0] frames[$];
  int          fbits[$];
  int          hi_len[$];

  initial begin
    forever begin
      @(negedge CLK);
      cyc = cyc + 1;
      if (rst_prev) begin
        cap = 32'd0; nbits = 0; last_rise = -1; le_rise = -1;
      end else begin
        if (ADF_CLK && !prev_clk && !ADF_LE) begin
          cap   = {cap[30:0], ADF_DATA};
          nbits = nbits + 1;
          if (last_rise >= 0 && (cyc - last_rise) != 4) gap_bad = gap_bad + 1;
          last_rise = cyc;
        end
        if (!ADF_LE && prev_le && le_rise >= 0) hi_len.push_back(cyc - le_rise);
        if (ADF_LE && !prev_le) begin
          frames.push_back(cap);
          fbits.push_back(nbits);
          cap = 32'd0; nbits = 0; last_rise = -1; le_rise = cyc;
        end
        if (WORD_DONE) wd_cnt = wd_cnt + 1;
        if (SEQ_DONE) sd_cnt = sd_cnt + 1;
        if (prev_busy && !BUSY) busy_falls = busy_falls + 1;
      end
      prev_clk  = ADF_CLK;
      prev_le   = ADF_LE;
      prev_busy = BUSY;
      rst_prev  = RST;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    frames.delete(); fbits.delete(); hi_len.delete();
    gap_bad = 0; wd_cnt = 0; sd_cnt = 0; busy_falls = 0; le_rise = -1;
  endtask

  task automatic push(input logic [31:0] w);
    WR_VALID = 1'b1;
    WR_DATA  = w;
    step();
    WR_VALID = 1'b0;
  endtask

  task automatic wait_sd(input int budget);
    int k = 0;
    while (sd_cnt < 1 && k < budget) begin
      step();
      k = k + 1;
    end
    chk("seq_done_within_budget", 32'(sd_cnt >= 1), 32'd1);
    repeat (3) step();
  endtask

  task automatic wait_le_low(input int budget);
    int k = 0;
    while (ADF_LE && k < budget) begin
      step();
      k = k + 1;
    end
    chk("le_low_within_budget", {31'd0, ADF_LE}, 32'd0);
  endtask

  task automatic chk_frame(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    int          nb;
    got = (idx < frames.size()) ? frames[idx] : 32'hDEAD_BEEF;
    nb  = (idx < fbits.size()) ? fbits[idx] : -1;
    chk(name, got, exp);
    chk({name, "_bits"}, 32'(nb), 32'd32);
  endtask

  initial begin
    int k;
    logic [31:0] w;
    vecs[0] = '{32'h0058_0005, 32'h0058_0005, 32};
    vecs[1] = '{32'h008C_803C, 32'h008C_803C, 32};
    vecs[2] = '{32'h0000_04B3, 32'h0000_04B3, 32};
    vecs[3] = '{32'h0000_4E42, 32'h0000_4E42, 32};
    vecs[4] = '{32'h0800_8011, 32'h0800_8011, 32};
    vecs[5] = '{32'h0040_0000, 32'h0040_0000, 32};

    RST = 1'b1; WR_VALID = 1'b0; WR_DATA = 32'd0; WR_VALID5 = 1'b0; WR_DATA5 = 24'd0;
    repeat (3) step();
    chk("rst_le", {31'd0, ADF_LE}, 32'd1);
    chk("rst_clk", {31'd0, ADF_CLK}, 32'd0);
    chk("rst_data", {31'd0, ADF_DATA}, 32'd0);
    chk("rst_ready", {31'd0, WR_READY}, 32'd1);
    chk("rst_level", {28'd0, LEVEL}, 32'd0);
    chk("rst_busy_ovf_pulses", {28'd0, BUSY, OVF, WORD_DONE, SEQ_DONE}, 32'd0);
    RST = 1'b0;
    step();
    clr_mon();

    // Single word: LE falls two edges after the push edge.
    push(32'h0058_0005);
    chk("t1_level_after_push", {28'd0, LEVEL}, 32'd1);
    chk("t1_le_still_high", {31'd0, ADF_LE}, 32'd1);
    step();
    chk("t1_le_high_n1", {31'd0, ADF_LE}, 32'd1);
    chk("t1_busy_n1", {31'd0, BUSY}, 32'd1);
    chk("t1_level_n1", {28'd0, LEVEL}, 32'd0);
    step();
    chk("t1_le_low_n2", {31'd0, ADF_LE}, 32'd0);
    wait_sd(400);
    chk("t1_frames", 32'(frames.size()), 32'd1);
    chk_frame("t1_word", 0, 32'h0058_0005);
    chk("t1_rise_gap", 32'(gap_bad), 32'd0);
    chk("t1_word_done", 32'(wd_cnt), 32'd1);
    chk("t1_seq_done", 32'(sd_cnt), 32'd1);

    // Burst of six register words from the table.
    clr_mon();
    for (int i = 0; i < 6; i++) push(vecs[i].wdata);
    wait_sd(1500);
    chk("t2_frames", 32'(frames.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_word%0d", i), (i < frames.size()) ? frames[i] : 32'hDEAD_BEEF, vecs[i].exp_word);
      chk($sformatf("t2_bits%0d", i), 32'((i < fbits.size()) ? fbits[i] : -1), 32'(vecs[i].exp_bits));
    end
    chk("t2_le_gaps", 32'(hi_len.size()), 32'd5);
    for (int i = 0; i < hi_len.size(); i++) chk($sformatf("t2_le_hi%0d", i), 32'(hi_len[i]), 32'd3);
    chk("t2_busy_falls", 32'(busy_falls), 32'd1);
    chk("t2_word_done", 32'(wd_cnt), 32'd6);
    chk("t2_rise_gap", 32'(gap_bad), 32'd0);

    // Overflow while a word shifts.
    clr_mon();
    push(32'hA5C3_0000);
    wait_le_low(10);
    for (int i = 1; i <= 9; i++) begin
      push(32'hA5C3_0000 + 32'(i));
      if (i == 8) begin
        chk("t3_level_full", {28'd0, LEVEL}, 32'd8);
        chk("t3_ready_low", {31'd0, WR_READY}, 32'd0);
        chk("t3_ovf_before", {31'd0, OVF}, 32'd0);
      end
    end
    chk("t3_ovf_set", {31'd0, OVF}, 32'd1);
    chk("t3_level_held", {28'd0, LEVEL}, 32'd8);
    wait_sd(1800);
    chk("t3_frames", 32'(frames.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk_frame($sformatf("t3_word%0d", i), i, 32'hA5C3_0000 + 32'(i));
    chk("t3_ovf_sticky", {31'd0, OVF}, 32'd1);

    // Reset part way through a word.
    clr_mon();
    push(32'h1234_5678);
    wait_le_low(10);
    push(32'h0F0F_0F0F);
    k = 0;
    while (nbits < 17 && k < 200) begin
      step();
      k = k + 1;
    end
    chk("t4_reached_bit17", 32'(nbits), 32'd17);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t4_le", {31'd0, ADF_LE}, 32'd1);
    chk("t4_clk", {31'd0, ADF_CLK}, 32'd0);
    chk("t4_level", {28'd0, LEVEL}, 32'd0);
    chk("t4_busy", {31'd0, BUSY}, 32'd0);
    chk("t4_ovf_cleared", {31'd0, OVF}, 32'd0);
    repeat (5) step();
    chk("t4_no_word_done", 32'(wd_cnt), 32'd0);
    chk("t4_no_frame", 32'(frames.size()), 32'd0);
    push(32'hC0DE_0001);
    wait_sd(400);
    chk("t4_frames", 32'(frames.size()), 32'd1);
    chk_frame("t4_word", 0, 32'hC0DE_0001);

    // Push into a full FIFO on the cycle of an internal pop.
    clr_mon();
    push(32'h6000_0000);
    wait_le_low(10);
    for (int i = 1; i <= 8; i++) push(32'h6000_0000 + 32'(i));
    chk("t6_level_full", {28'd0, LEVEL}, 32'd8);
    k = 0;
    while (!WORD_DONE && k < 300) begin
      step();
      k = k + 1;
    end
    chk("t6_word_done_seen", {31'd0, WORD_DONE}, 32'd1);
    step();
    chk("t6_level_pre", {28'd0, LEVEL}, 32'd8);
    chk("t6_ovf_pre", {31'd0, OVF}, 32'd0);
    push(32'hBAD0_BAD0);
    chk("t6_level_dec", {28'd0, LEVEL}, 32'd7);
    chk("t6_ovf_set", {31'd0, OVF}, 32'd1);
    wait_sd(1500);
    chk("t6_frames", 32'(frames.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk_frame($sformatf("t6_word%0d", i), i, 32'h6000_0000 + 32'(i));

    // 24-bit build, 2-cycle bit period, 51-cycle word.
    begin
      int          c = 0, fall1 = -1, fall2 = -1, rise1 = -1, lr = -1, bad5 = 0, nb5 = 0, nfr = 0;
      logic [23:0] cap5 = 24'd0, fr0 = 24'd0, fr1 = 24'd0;
      int          nb0 = 0;
      logic        pc = 1'b0, pl = 1'b1;
      WR_VALID5 = 1'b1; WR_DATA5 = 24'hABCDEF;
      step();
      WR_DATA5 = 24'h123456;
      step();
      WR_VALID5 = 1'b0;
      for (int i = 0; i < 200; i++) begin
        step();
        c = c + 1;
        if (ADF_CLK5 && !pc && !ADF_LE5) begin
          cap5 = {cap5[22:0], ADF_DATA5};
          nb5  = nb5 + 1;
          if (lr >= 0 && (c - lr) != 2) bad5 = bad5 + 1;
          lr = c;
        end
        if (!ADF_LE5 && pl) begin
          if (fall1 < 0) fall1 = c;
          else if (fall2 < 0) fall2 = c;
        end
        if (ADF_LE5 && !pl) begin
          if (nfr == 0) begin fr0 = cap5; nb0 = nb5; rise1 = c; end
          else if (nfr == 1) fr1 = cap5;
          nfr = nfr + 1; cap5 = 24'd0; nb5 = 0; lr = -1;
        end
        pc = ADF_CLK5;
        pl = ADF_LE5;
      end
      chk("t5_frames", 32'(nfr), 32'd2);
      chk("t5_word0", {8'd0, fr0}, 32'h00AB_CDEF);
      chk("t5_bits0", 32'(nb0), 32'd24);
      chk("t5_word1", {8'd0, fr1}, 32'h0012_3456);
      chk("t5_rise_gap", 32'(bad5), 32'd0);
      chk("t5_le_low_len", 32'(rise1 - fall1), 32'd49);
      chk("t5_word_time", 32'(fall2 - fall1), 32'd51);
      chk("t5_idle_level", {28'd0, LEVEL5, BUSY5}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
